// File: rtl/itcm_port_arbiter.sv
// Arbitrates the single ITCM read/write port between the LSU (MEMEX stage) and the program loader.
// The policy is round-robin on contention, and the loader can lock the port for a burst with a forced yield to the LSU.
module itcm_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [11:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [11:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  input  logic        ldr_lock,
  output logic        ldr_gnt,
  output logic        ldr_rvalid,
  output logic [31:0] ldr_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_lsu,
  output logic        misalign_err
);

  localparam logic [0:0] ST_SHARED = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]  state;
  logic        last_ldr;
  logic [3:0]  burst_cnt;
  logic [3:0]  cnt_next;
  logic        forced_yield;
  logic        lsu_mis;
  logic        ldr_mis;
  logic [31:0] lsu_rdata_q;
  logic [31:0] ldr_rdata_q;

  assign lsu_mis = (lsu_addr[1:0] != 2'b00);
  assign ldr_mis = (ldr_addr[1:0] != 2'b00);

  // On contention, last_ldr=1 means the loader won last time, so the LSU goes next.
  always_comb begin
    lsu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    if (state == ST_LOCKED) begin
      ldr_gnt = ldr_req;
    end else if (lsu_req && ldr_req) begin
      lsu_gnt = last_ldr;
      ldr_gnt = ~last_ldr;
    end else begin
      lsu_gnt = lsu_req;
      ldr_gnt = ldr_req;
    end
  end

  assign stall_lsu = lsu_req & ~lsu_gnt;

  // Misaligned accesses are granted so the requester moves on, but never reach the memory.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 12'h000;
    mem_wdata = 32'h0000_0000;
    if (lsu_gnt && !lsu_mis) begin
      mem_en    = 1'b1;
      mem_we    = lsu_we;
      mem_addr  = lsu_addr;
      mem_wdata = lsu_wdata;
    end else if (ldr_gnt && !ldr_mis) begin
      mem_en    = 1'b1;
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end
  end

  assign cnt_next     = (ldr_gnt && burst_cnt != 4'hF) ? burst_cnt + 4'd1 : burst_cnt;
  assign forced_yield = (state == ST_LOCKED) && lsu_req && (cnt_next == 4'hF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_SHARED;
      last_ldr  <= 1'b1;
      burst_cnt <= 4'h0;
    end else begin
      if (lsu_gnt) begin
        last_ldr <= 1'b0;
      end else if (ldr_gnt) begin
        last_ldr <= 1'b1;
      end
      if (state == ST_SHARED) begin
        burst_cnt <= 4'h0;
        if (ldr_gnt && ldr_lock) begin
          state <= ST_LOCKED;
        end
      end else begin
        burst_cnt <= cnt_next;
        if (!ldr_lock || forced_yield) begin
          state <= ST_SHARED;
        end
        if (forced_yield) begin
          last_ldr <= 1'b1;
        end
      end
    end
  end

  // The memory answers one cycle after mem_en, so rvalid is just the registered read grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsu_rvalid   <= 1'b0;
      ldr_rvalid   <= 1'b0;
      misalign_err <= 1'b0;
      lsu_rdata_q  <= 32'h0000_0000;
      ldr_rdata_q  <= 32'h0000_0000;
    end else begin
      lsu_rvalid   <= lsu_gnt & ~lsu_we & ~lsu_mis;
      ldr_rvalid   <= ldr_gnt & ~ldr_we & ~ldr_mis;
      misalign_err <= (lsu_gnt & lsu_mis) | (ldr_gnt & ldr_mis);
      if (lsu_rvalid) begin
        lsu_rdata_q <= mem_rdata;
      end
      if (ldr_rvalid) begin
        ldr_rdata_q <= mem_rdata;
      end
    end
  end

  assign lsu_rdata = lsu_rvalid ? mem_rdata : lsu_rdata_q;
  assign ldr_rdata = ldr_rvalid ? mem_rdata : ldr_rdata_q;

endmodule
